window_buffer_3x3_stream: RTL and testbench

Parametrised 3x3 sliding-window generator for the conv/pool front end, sitting between the pixel stream source and the PE array. It accepts one frame of raster-order pixels over a valid/ready handshake and emits packed 3x3 windows over a second valid/ready handshake. Runtime options cover padding mode (zero-pad "same" or "valid") and stride (1 or 2). Output backpressure propagates to the input.

---
 rtl/window_buffer_3x3_stream.sv | 234 +++++++++++++++++++++++
 tb/tb_window_buffer_3x3_stream.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/window_buffer_3x3_stream.sv
// window_buffer_3x3_stream: streams a raster frame through three circular row
// buffers and emits packed 3x3 windows (zero-pad "same" or "valid", stride 1/2).
// Ports:
//   clk, rst_n                    clock, asynchronous active-low reset
//   start_i                       one-cycle pulse latching the config (IDLE only)
//   img_width_i, img_height_i     frame size W (3..MAX_WIDTH), H (>=3)
//   pad_mode_i, stride_i          1 = zero-pad same / 1 = stride 2
//   in_valid_i/in_ready_o/in_data_i          raster-order pixel stream
//   out_valid_o/out_ready_i/out_window_o     window stream, tap 3*row+col
//   out_last_o                    marks the final window of the frame
//   busy_o, done_o, cfg_err_o     status: not IDLE / frame finished / bad config
module window_buffer_3x3_stream #(
    parameter int DATA_W    = 8,
    parameter int MAX_WIDTH = 256,
    parameter int DIM_W     = 9
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start_i,
    input  logic [DIM_W-1:0]    img_width_i,
    input  logic [DIM_W-1:0]    img_height_i,
    input  logic                pad_mode_i,
    input  logic                stride_i,
    input  logic                in_valid_i,
    output logic                in_ready_o,
    input  logic [DATA_W-1:0]   in_data_i,
    output logic                out_valid_o,
    input  logic                out_ready_i,
    output logic [9*DATA_W-1:0] out_window_o,
    output logic                out_last_o,
    output logic                busy_o,
    output logic                done_o,
    output logic                cfg_err_o
);
    localparam int AW = (MAX_WIDTH > 1) ? $clog2(MAX_WIDTH) : 1;
    localparam int CW = DIM_W + 1;

    typedef enum logic [1:0] {IDLE, FILL, FLUSH} state_t;

    function automatic logic [1:0] mod3(input logic [2:0] v);
        return (v >= 3'd6) ? 2'(v - 3'd6) : (v >= 3'd3) ? 2'(v - 3'd3) : v[1:0];
    endfunction

    state_t               state_q, state_d;
    logic [DIM_W-1:0]     w_q, w_d, h_q, h_d;
    logic                 pad_q, pad_d, str_q, str_d;
    logic [DIM_W-1:0]     in_r_q, in_r_d, in_c_q, in_c_d;
    logic [1:0]           in_r3_q, in_r3_d;
    logic [DIM_W-1:0]     win_r_q, win_r_d, win_c_q, win_c_d;
    logic [1:0]           win_r3_q, win_r3_d;
    logic                 wins_done_q, wins_done_d, last_acc_q, last_acc_d;
    logic                 ov_q, ov_d, ol_q, ol_d, done_q, done_d, err_q, err_d;
    logic [9*DATA_W-1:0]  ow_q, ow_d;
    logic [DATA_W-1:0]    rows_q [3][MAX_WIDTH];

    logic [CW-1:0]        w_x, h_x, r_x, c_x, in_r_x, in_c_x;
    logic [CW-1:0]        r1, c1, rr, rc, rmax, cmax;
    logic [DIM_W-1:0]     stp;
    logic                 cfg_bad, rdy_pix, win_rdy, out_free, load, out_acc;
    logic                 in_acc, in_row_end, in_last, row_end, last_win;
    logic [9*DATA_W-1:0]  win_w;

    assign w_x    = CW'(w_q);
    assign h_x    = CW'(h_q);
    assign r_x    = CW'(win_r_q);
    assign c_x    = CW'(win_c_q);
    assign in_r_x = CW'(in_r_q);
    assign in_c_x = CW'(in_c_q);
    assign stp    = str_q ? DIM_W'(2) : DIM_W'(1);

    assign cfg_bad = img_width_i < DIM_W'(3) || CW'(img_width_i) > CW'(MAX_WIDTH) ||
                     img_height_i < DIM_W'(3);

    // Required pixel: the bottom-right tap, clamped to the frame edge in pad mode.
    assign r1   = r_x + CW'(1);
    assign c1   = c_x + CW'(1);
    assign rr   = pad_q ? ((r1 > h_x - CW'(1)) ? h_x - CW'(1) : r1) : r_x + CW'(2);
    assign rc   = pad_q ? ((c1 > w_x - CW'(1)) ? w_x - CW'(1) : c1) : c_x + CW'(2);
    assign rmax = h_x - (pad_q ? CW'(1) : CW'(3));
    assign cmax = w_x - (pad_q ? CW'(1) : CW'(3));

    // Once the last pixel is in, every remaining window is ready.
    assign rdy_pix  = state_q == FLUSH || in_r_x > rr || (in_r_x == rr && in_c_x > rc);
    assign win_rdy  = state_q != IDLE && !wins_done_q && rdy_pix;
    assign out_free = !ov_q || out_ready_i;
    assign load     = win_rdy && out_free;
    assign out_acc  = ov_q && out_ready_i;

    // Input stalls while a window is ready, so at most one window is ever pending
    // and a row is never overwritten before its last window has been captured.
    assign in_ready_o = state_q == FILL && !win_rdy && out_free;
    assign in_acc     = in_valid_i && in_ready_o;
    assign in_row_end = in_c_x == w_x - CW'(1);
    assign in_last    = in_row_end && in_r_x == h_x - CW'(1);

    assign row_end  = c_x + CW'(stp) > cmax;
    assign last_win = row_end && r_x + CW'(stp) > rmax;

    // Tap (i,j) reads row (r+i-pad) from buffer (row mod 3); -1 mod 3 == 2.
    for (genvar i = 0; i < 3; i++) begin : g_row
        for (genvar j = 0; j < 3; j++) begin : g_col
            logic [1:0]    sel;
            logic [AW-1:0] col;
            logic          zero;
            assign sel  = mod3(3'(win_r3_q) + 3'(i) + (pad_q ? 3'd2 : 3'd0));
            assign col  = win_c_q[AW-1:0] + AW'(j) - (pad_q ? AW'(1) : AW'(0));
            assign zero = pad_q && ((i == 0 && win_r_q == '0) || (i == 2 && r_x == h_x - CW'(1)) ||
                                    (j == 0 && win_c_q == '0) || (j == 2 && c_x == w_x - CW'(1)));
            assign win_w[(3*i+j)*DATA_W +: DATA_W] = zero ? '0 : rows_q[sel][col];
        end
    end

    always_comb begin
        state_d     = state_q;
        w_d         = w_q;
        h_d         = h_q;
        pad_d       = pad_q;
        str_d       = str_q;
        in_r_d      = in_r_q;
        in_c_d      = in_c_q;
        in_r3_d     = in_r3_q;
        win_r_d     = win_r_q;
        win_c_d     = win_c_q;
        win_r3_d    = win_r3_q;
        wins_done_d = wins_done_q;
        last_acc_d  = last_acc_q;
        ov_d        = ov_q;
        ol_d        = ol_q;
        ow_d        = ow_q;
        done_d      = 1'b0;
        err_d       = 1'b0;
        case (state_q)
            IDLE: if (start_i) begin
                if (cfg_bad) begin
                    err_d = 1'b1;
                end else begin
                    state_d     = FILL;
                    w_d         = img_width_i;
                    h_d         = img_height_i;
                    pad_d       = pad_mode_i;
                    str_d       = stride_i;
                    in_r_d      = '0;
                    in_c_d      = '0;
                    in_r3_d     = '0;
                    win_r_d     = '0;
                    win_c_d     = '0;
                    win_r3_d    = '0;
                    wins_done_d = 1'b0;
                    last_acc_d  = 1'b0;
                end
            end
            FILL: if (in_acc && in_last) state_d = FLUSH;
            // The last window may already have been taken while pixels were still arriving.
            FLUSH: if (last_acc_q || (out_acc && ol_q)) begin
                state_d = IDLE;
                done_d  = 1'b1;
            end
            default: state_d = IDLE;
        endcase
        if (in_acc) begin
            in_c_d  = in_row_end ? '0 : in_c_q + DIM_W'(1);
            in_r_d  = in_row_end ? in_r_q + DIM_W'(1) : in_r_q;
            in_r3_d = in_row_end ? mod3(3'(in_r3_q) + 3'd1) : in_r3_q;
        end
        if (out_acc) begin
            ov_d       = 1'b0;
            ol_d       = 1'b0;
            last_acc_d = last_acc_q | ol_q;
        end
        if (load) begin
            ov_d        = 1'b1;
            ol_d        = last_win;
            ow_d        = win_w;
            win_c_d     = row_end ? '0 : win_c_q + stp;
            win_r_d     = row_end ? win_r_q + stp : win_r_q;
            win_r3_d    = row_end ? mod3(3'(win_r3_q) + (str_q ? 3'd2 : 3'd1)) : win_r3_q;
            wins_done_d = wins_done_q | last_win;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            w_q         <= '0;
            h_q         <= '0;
            pad_q       <= 1'b0;
            str_q       <= 1'b0;
            in_r_q      <= '0;
            in_c_q      <= '0;
            in_r3_q     <= '0;
            win_r_q     <= '0;
            win_c_q     <= '0;
            win_r3_q    <= '0;
            wins_done_q <= 1'b0;
            last_acc_q  <= 1'b0;
            ov_q        <= 1'b0;
            ol_q        <= 1'b0;
            ow_q        <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            w_q         <= w_d;
            h_q         <= h_d;
            pad_q       <= pad_d;
            str_q       <= str_d;
            in_r_q      <= in_r_d;
            in_c_q      <= in_c_d;
            in_r3_q     <= in_r3_d;
            win_r_q     <= win_r_d;
            win_c_q     <= win_c_d;
            win_r3_q    <= win_r3_d;
            wins_done_q <= wins_done_d;
            last_acc_q  <= last_acc_d;
            ov_q        <= ov_d;
            ol_q        <= ol_d;
            ow_q        <= ow_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    // Row storage needs no reset: padded taps are zeroed by position.
    always_ff @(posedge clk) begin
        if (in_acc) rows_q[in_r3_q][in_c_q[AW-1:0]] <= in_data_i;
    end

    assign out_valid_o  = ov_q;
    assign out_window_o = ow_q;
    assign out_last_o   = ol_q;
    assign busy_o       = state_q != IDLE;
    assign done_o       = done_q;
    assign cfg_err_o    = err_q;
endmodule

// File: tb/tb_window_buffer_3x3_stream.sv
// tb_window_buffer_3x3_stream: directed and random frames checked against a window model.
module tb_window_buffer_3x3_stream;
    localparam int DW  = 8;
    localparam int MW  = 256;
    localparam int DMW = 9;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start_i = 1'b0;
    logic [DMW-1:0]    img_width_i = '0;
    logic [DMW-1:0]    img_height_i = '0;
    logic              pad_mode_i = 1'b0;
    logic              stride_i = 1'b0;
    logic              in_valid_i = 1'b0;
    logic              in_ready_o;
    logic [DW-1:0]     in_data_i = '0;
    logic              out_valid_o;
    logic              out_ready_i = 1'b0;
    logic [9*DW-1:0]   out_window_o;
    logic              out_last_o;
    logic              busy_o;
    logic              done_o;
    logic              cfg_err_o;

    int checks = 0;
    int errors = 0;
    int pix[$];
    logic [9*DW-1:0] exp_q[$];
    logic [9*DW-1:0] got_q[$];

    window_buffer_3x3_stream #(.DATA_W(DW), .MAX_WIDTH(MW), .DIM_W(DMW)) dut (
        .clk(clk), .rst_n(rst_n), .start_i(start_i),
        .img_width_i(img_width_i), .img_height_i(img_height_i),
        .pad_mode_i(pad_mode_i), .stride_i(stride_i),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .in_data_i(in_data_i),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_window_o(out_window_o),
        .out_last_o(out_last_o), .busy_o(busy_o), .done_o(done_o), .cfg_err_o(cfg_err_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [9*DW-1:0] obs, input logic [9*DW-1:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [9*DW-1:0] pk(input int t[9]);
        logic [9*DW-1:0] r;
        int x;
        r = '0;
        for (int k = 0; k < 9; k++) begin
            x = t[k];
            r[k*DW +: DW] = x[DW-1:0];
        end
        return r;
    endfunction

    task automatic seq_pix(input int n);
        pix.delete();
        for (int k = 0; k < n; k++) pix.push_back(k + 1);
    endtask

    task automatic rand_pix(input int n);
        pix.delete();
        for (int k = 0; k < n; k++) pix.push_back(int'($urandom_range(0, 255)));
    endtask

    // Every window position in raster order; taps outside the image read as 0.
    task automatic build_model(input int w, input int h, input bit pad, input bit s);
        int st;
        st = s ? 2 : 1;
        exp_q.delete();
        for (int r = 0; pad ? r < h : r <= h - 3; r += st) begin
            for (int c = 0; pad ? c < w : c <= w - 3; c += st) begin
                logic [9*DW-1:0] v;
                int pr, pc, x;
                v = '0;
                for (int i = 0; i < 3; i++) begin
                    for (int j = 0; j < 3; j++) begin
                        pr = pad ? r + i - 1 : r + i;
                        pc = pad ? c + j - 1 : c + j;
                        if (pr >= 0 && pr < h && pc >= 0 && pc < w) begin
                            x = pix[pr*w + pc];
                            v[(3*i+j)*DW +: DW] = x[DW-1:0];
                        end
                    end
                end
                exp_q.push_back(v);
            end
        end
    endtask

    task automatic do_start(input int w, input int h, input bit pad, input bit s);
        img_width_i  = w[DMW-1:0];
        img_height_i = h[DMW-1:0];
        pad_mode_i   = pad;
        stride_i     = s;
        start_i      = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
    endtask

    task automatic bad_start(input int w, input int h);
        do_start(w, h, 1'b1, 1'b0);
        chk("cfg_err_pulse", cfg_err_o, 1);
        chk("cfg_err_busy", busy_o, 0);
        chk("cfg_err_no_out", out_valid_o, 0);
        @(posedge clk); #1;
        chk("cfg_err_clear", cfg_err_o, 0);
        chk("cfg_err_idle", busy_o, 0);
    endtask

    task automatic run_frame(input int w, input int h, input bit pad, input bit s,
                             input bit rnd, input bit lat);
        int pi, wi, cyc, lpc, fov, n, dn, t;
        bit stall;
        logic [9*DW-1:0] held;
        n = w * h;
        build_model(w, h, pad, s);
        got_q.delete();
        do_start(w, h, pad, s);
        chk("busy_rise", busy_o, 1);
        chk("cfg_err_legal", cfg_err_o, 0);
        pi = 0; wi = 0; cyc = 0; lpc = -1; fov = -1; dn = 0; stall = 0; held = '0;
        while (dn == 0 && cyc < 20*n + 200) begin
            in_valid_i = (pi < n) && (!rnd || $urandom_range(0, 9) != 0);
            t = (pi < n) ? pix[pi] : 0;
            in_data_i = t[DW-1:0];
            out_ready_i = !rnd || $urandom_range(0, 9) >= 3;
            @(negedge clk);
            if (stall) begin
                chk("hold_window", out_window_o, held);
                chk("hold_valid", out_valid_o, 1);
            end
            stall = out_valid_o && !out_ready_i;
            if (stall) begin
                held = out_window_o;
                chk("in_ready_stall", in_ready_o, 0);
            end
            if (in_valid_i && in_ready_o) begin
                pi++;
                if (pi == n) lpc = cyc;
            end
            if (out_valid_o && fov < 0) fov = cyc;
            if (out_valid_o && out_ready_i) begin
                got_q.push_back(out_window_o);
                if (wi < exp_q.size()) begin
                    chk("window", out_window_o, exp_q[wi]);
                    chk("out_last", out_last_o, wi == exp_q.size() - 1);
                end else begin
                    chk("extra_window", wi, exp_q.size());
                end
                wi++;
            end
            if (done_o) begin
                dn = 1;
                chk("busy_at_done", busy_o, 0);
            end
            @(posedge clk); #1;
            cyc++;
        end
        in_valid_i  = 1'b0;
        out_ready_i = 1'b0;
        chk("frame_done", dn, 1);
        chk("window_count", wi, exp_q.size());
        @(negedge clk);
        chk("done_single", done_o, 0);
        chk("busy_idle", busy_o, 0);
        if (lat) chk("latency", fov, lpc + 2);
        @(posedge clk); #1;
    endtask

    task automatic check_4x4_pad();
        chk("pad4_first", got_q[0], pk('{0, 0, 0, 0, 1, 2, 0, 5, 6}));
        chk("pad4_last", got_q[got_q.size()-1], pk('{11, 12, 0, 15, 16, 0, 0, 0, 0}));
    endtask

    task automatic check_reset_outputs();
        chk("rst_out_valid", out_valid_o, 0);
        chk("rst_out_last", out_last_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_done", done_o, 0);
        chk("rst_cfg_err", cfg_err_o, 0);
        chk("rst_in_ready", in_ready_o, 0);
        chk("rst_out_window", out_window_o, '0);
    endtask

    initial begin
        int w, h, k, cyc, t;
        int sv[9];
        sv = '{-128, -1, 127, 0, 1, -2, 64, -64, -127};
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs();
        rst_n = 1'b1;
        @(posedge clk); #1;

        seq_pix(16);
        run_frame(4, 4, 1'b1, 1'b0, 1'b0, 1'b0);
        check_4x4_pad();

        seq_pix(25);
        run_frame(5, 5, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("v5_first", got_q[0], pk('{1, 2, 3, 6, 7, 8, 11, 12, 13}));
        chk("v5_last", got_q[got_q.size()-1], pk('{13, 14, 15, 18, 19, 20, 23, 24, 25}));

        seq_pix(16);
        run_frame(4, 4, 1'b1, 1'b0, 1'b1, 1'b0);
        check_4x4_pad();

        pix.delete();
        foreach (sv[i]) pix.push_back(sv[i]);
        run_frame(3, 3, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("signed_window", got_q[0], pk(sv));

        bad_start(2, 4);
        bad_start(MW + 1, 4);
        bad_start(4, 2);
        seq_pix(16);
        run_frame(4, 4, 1'b1, 1'b0, 1'b0, 1'b0);
        check_4x4_pad();

        do_start(4, 4, 1'b1, 1'b0);
        k = 0; cyc = 0;
        out_ready_i = 1'b1;
        while (k < 7 && cyc < 100) begin
            in_valid_i = 1'b1;
            t = pix[k];
            in_data_i = t[DW-1:0];
            @(negedge clk);
            if (in_ready_o) k++;
            @(posedge clk); #1;
            cyc++;
        end
        in_valid_i  = 1'b0;
        out_ready_i = 1'b0;
        chk("rst_feed", k, 7);
        #2 rst_n = 1'b0;
        #1;
        check_reset_outputs();
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_frame(4, 4, 1'b1, 1'b0, 1'b0, 1'b0);
        check_4x4_pad();

        for (int f = 0; f < 6; f++) begin
            w = int'($urandom_range(3, 11));
            h = int'($urandom_range(3, 9));
            rand_pix(w * h);
            run_frame(w, h, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1, 1'b0);
        end

        rand_pix(MW * 3);
        run_frame(MW, 3, 1'b1, 1'b0, 1'b0, 1'b0);
        rand_pix(MW * 4);
        run_frame(MW, 4, 1'b0, 1'b1, 1'b1, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
